id_exe_stage_reg: RTL and testbench



---
 rtl/id_exe_stage_reg.sv | 117 +++++++++++
 tb/tb_id_exe_stage_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register. Captures the decoded instruction from ID and
// presents it to EXE for one cycle. Supports freeze (hold), flush and
// bubble (both load a NOP with valid_out=0). Reset is synchronous, active-high.
module id_exe_stage_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic        imm_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic        src2_used_in,
  input  logic [3:0]  status_in,
  output logic [31:0] pc_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic        imm_out,
  output logic [3:0]  exe_cmd_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic [11:0] shift_operand_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic        src2_used_out,
  output logic [3:0]  status_out,
  output logic        valid_out
);

  logic squash;
  assign squash = flush | bubble;

  // Data payload: follows ID whenever not frozen; a NOP does not need to
  // clear it because EXE ignores it while valid_out is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out            <= 32'd0;
      val_rn_out        <= 32'd0;
      val_rm_out        <= 32'd0;
      shift_operand_out <= 12'd0;
      signed_imm_24_out <= 24'd0;
      imm_out           <= 1'b0;
      status_out        <= 4'd0;
    end else if (!freeze) begin
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      imm_out           <= imm_in;
      status_out        <= status_in;
    end
  end

  // Control and register numbers: cleared on a NOP so neither the enables
  // nor stale register numbers can trigger forwarding or side effects.
  // An unused second source is reported as register 0 for the same reason.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= 1'b0;
      wb_en_out     <= 1'b0;
      mem_r_en_out  <= 1'b0;
      mem_w_en_out  <= 1'b0;
      b_out         <= 1'b0;
      s_out         <= 1'b0;
      src2_used_out <= 1'b0;
      exe_cmd_out   <= 4'd0;
      dest_out      <= 4'd0;
      src1_out      <= 4'd0;
      src2_out      <= 4'd0;
    end else if (!freeze) begin
      if (squash) begin
        valid_out     <= 1'b0;
        wb_en_out     <= 1'b0;
        mem_r_en_out  <= 1'b0;
        mem_w_en_out  <= 1'b0;
        b_out         <= 1'b0;
        s_out         <= 1'b0;
        src2_used_out <= 1'b0;
        exe_cmd_out   <= 4'd0;
        dest_out      <= 4'd0;
        src1_out      <= 4'd0;
        src2_out      <= 4'd0;
      end else begin
        valid_out     <= 1'b1;
        wb_en_out     <= wb_en_in;
        mem_r_en_out  <= mem_r_en_in;
        mem_w_en_out  <= mem_w_en_in;
        b_out         <= b_in;
        s_out         <= s_in;
        src2_used_out <= src2_used_in;
        exe_cmd_out   <= exe_cmd_in;
        dest_out      <= dest_in;
        src1_out      <= src1_in;
        src2_out      <= src2_used_in ? src2_in : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: the stimulus thread predicts the
// register contents after every edge and queues them; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, bubble;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, src2_used_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, src2_used_out, valid_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
    .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .src2_used_in(src2_used_in), .status_in(status_in),
    .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
    .exe_cmd_out(exe_cmd_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .src2_used_out(src2_used_out), .status_out(status_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // What EXE should see; chk_data says whether the payload fields are defined.
  typedef struct {
    logic        valid, wb_en, mem_r_en, mem_w_en, b, s, imm, src2_used, chk_data;
    logic [3:0]  exe_cmd, dest, src1, src2, status;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
  } exp_t;

  exp_t q[$];
  exp_t model;
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask

  // Randomize the whole ID instruction; directed tests override fields.
  task automatic rand_instr();
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, src2_used_in} = 7'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom); src1_in = 4'($urandom);
    src2_in = 4'($urandom); status_in = 4'($urandom);
    shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
  endtask

  // Apply one edge with the given controls and record the expected result.
  task automatic step(input logic r, input logic fz, input logic fl, input logic bb);
    exp_t e;
    rst = r; freeze = fz; flush = fl; bubble = bb;
    @(posedge clk);
    e = model;
    if (r) begin
      e = '{default: '0};
      e.chk_data = 1'b1;
    end else if (fz) begin
      e = model;
    end else if (fl || bb) begin
      e = '{default: '0};
      e.chk_data = 1'b0;
    end else begin
      e.valid = 1'b1; e.chk_data = 1'b1;
      e.wb_en = wb_en_in; e.mem_r_en = mem_r_en_in; e.mem_w_en = mem_w_en_in;
      e.b = b_in; e.s = s_in; e.imm = imm_in; e.src2_used = src2_used_in;
      e.exe_cmd = exe_cmd_in; e.dest = dest_in; e.src1 = src1_in;
      e.src2 = src2_used_in ? src2_in : 4'd0;
      e.status = status_in; e.pc = pc_in; e.val_rn = val_rn_in; e.val_rm = val_rm_in;
      e.shift_operand = shift_operand_in; e.signed_imm_24 = signed_imm_24_in;
    end
    model = e;
    q.push_back(e);
    #1;
  endtask

  // Monitor: one prediction per edge, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("valid_out", 32'(valid_out), 32'(e.valid));
      check("wb_en_out", 32'(wb_en_out), 32'(e.wb_en));
      check("mem_r_en_out", 32'(mem_r_en_out), 32'(e.mem_r_en));
      check("mem_w_en_out", 32'(mem_w_en_out), 32'(e.mem_w_en));
      check("b_out", 32'(b_out), 32'(e.b));
      check("s_out", 32'(s_out), 32'(e.s));
      check("src2_used_out", 32'(src2_used_out), 32'(e.src2_used));
      check("exe_cmd_out", 32'(exe_cmd_out), 32'(e.exe_cmd));
      check("dest_out", 32'(dest_out), 32'(e.dest));
      check("src1_out", 32'(src1_out), 32'(e.src1));
      check("src2_out", 32'(src2_out), 32'(e.src2));
      if (e.chk_data) begin
        check("pc_out", pc_out, e.pc);
        check("val_rn_out", val_rn_out, e.val_rn);
        check("val_rm_out", val_rm_out, e.val_rm);
        check("shift_operand_out", 32'(shift_operand_out), 32'(e.shift_operand));
        check("signed_imm_24_out", 32'(signed_imm_24_out), 32'(e.signed_imm_24));
        check("imm_out", 32'(imm_out), 32'(e.imm));
        check("status_out", 32'(status_out), 32'(e.status));
      end
      if (!valid_out)
        check("nop_ctl_invariant", 32'({wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out}), 32'd0);
    end
  end

  initial begin
    model = '{default: '0};
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    // Reset with every input nonzero.
    pc_in = '1; val_rn_in = '1; val_rm_in = '1;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, src2_used_in} = '1;
    exe_cmd_in = '1; dest_in = '1; src1_in = '1; src2_in = '1; status_in = '1;
    shift_operand_in = '1; signed_imm_24_in = '1;
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Three back-to-back ADDs.
    for (int i = 1; i <= 3; i++) begin
      rand_instr(); wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
      exe_cmd_in = 4'd2; dest_in = 4'(i);
      step(0, 0, 0, 0);
    end

    // LDR, then freeze+flush for 3 cycles, then release.
    rand_instr(); mem_r_en_in = 1; wb_en_in = 1; dest_in = 4'd5;
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      step(0, 1, 1, 0);
    end
    rand_instr();
    step(0, 0, 0, 0);

    // Bubble on SUB, then SUB loads.
    rand_instr(); wb_en_in = 1; src1_in = 4'd5; exe_cmd_in = 4'd4;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Flush on STR, then flush+bubble together.
    rand_instr(); mem_w_en_in = 1; wb_en_in = 0;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);

    // Second-source masking.
    rand_instr(); src2_in = 4'd7; src2_used_in = 0;
    step(0, 0, 0, 0);
    src2_used_in = 1;
    step(0, 0, 0, 0);

    // Reset during freeze.
    rand_instr();
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    rand_instr();
    step(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int k;
      rand_instr();
      k = int'($urandom_range(0, 99));
      step(k < 3, k >= 3 && k < 25, (k % 7) == 0, (k % 5) == 0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
